// File: rtl/vga_sync_decoder.sv
// Rebuilds x/y/de from sampled 640x480-style syncs and locks after LOCK_FRAMES clean frames.
// Outputs register one clk after each pix_en sample; no backpressure, one sample per strobe.
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hsync_n,
    input  logic        vsync_n,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic        newline,
    output logic        newframe,
    output logic [11:0] h_total,
    output logic [11:0] v_total,
    output logic        locked,
    output logic        lock_err
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCK} state_t;

    state_t      state, state_nx;
    logic [7:0]  good_cnt, good_nx;
    logic        lock_err_nx;
    logic        hs_prev, vs_prev;
    logic [11:0] hcnt, hsw, lcnt, vsw;
    logic        seen_hs, line_bad;
    logic        hs_fall, hs_rise, vs_fall, vs_rise;
    logic        h_len_err, h_sync_err, v_sync_err, timeout;
    logic        line_err, timeout_err, frame_ok;
    logic        x_wrap;
    logic [9:0]  x_nx, y_nx;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    assign hs_fall = pix_en && !hsync_n && hs_prev;
    assign hs_rise = pix_en && hsync_n && !hs_prev;
    assign vs_fall = pix_en && !vsync_n && vs_prev;
    assign vs_rise = pix_en && vsync_n && !vs_prev;

    assign h_len_err  = hs_fall && (hcnt != 12'(H_TOTAL));
    assign h_sync_err = hs_rise && (hsw != 12'(H_SYNC));
    assign v_sync_err = vs_rise && (vsw != 12'(V_SYNC));
    // Fires once: hcnt saturates far above the threshold and cannot re-cross it.
    assign timeout    = pix_en && !hs_fall && (hcnt == 12'(2 * H_TOTAL - 1));

    assign timeout_err = seen_hs && timeout;
    assign line_err    = seen_hs && (h_len_err || h_sync_err || v_sync_err || timeout);
    assign frame_ok    = (lcnt == 12'(V_TOTAL)) && (vsw == 12'(V_SYNC)) && !line_bad && !line_err;

    assign x_wrap = !hs_fall && (x >= 10'(H_TOTAL - 1));

    always_comb begin
        x_nx = x;
        y_nx = y;
        if (hs_fall)
            x_nx = 10'(H_ACTIVE + H_FP);
        else if (x_wrap)
            x_nx = 10'd0;
        else
            x_nx = x + 10'd1;
        if (vs_fall)
            y_nx = 10'(V_ACTIVE + V_FP);
        else if (x_wrap)
            y_nx = (y >= 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_prev  <= 1'b1;
            vs_prev  <= 1'b1;
            x        <= '0;
            y        <= '0;
            newline  <= 1'b0;
            newframe <= 1'b0;
            hcnt     <= '0;
            hsw      <= '0;
            lcnt     <= '0;
            vsw      <= '0;
            h_total  <= '0;
            v_total  <= '0;
            seen_hs  <= 1'b0;
            line_bad <= 1'b0;
        end else begin
            newline  <= pix_en && (x_nx == 10'd0);
            newframe <= pix_en && (x_nx == 10'd0) && (y_nx == 10'd0);
            if (pix_en) begin
                hs_prev <= hsync_n;
                vs_prev <= vsync_n;
                x       <= x_nx;
                y       <= y_nx;

                if (hs_fall) begin
                    h_total <= hcnt;
                    hcnt    <= 12'd1;
                    hsw     <= 12'd1;
                    seen_hs <= 1'b1;
                end else begin
                    hcnt <= sat_inc(hcnt);
                    if (!hsync_n)
                        hsw <= sat_inc(hsw);
                end

                // A coincident hs_fall belongs to the frame that starts here.
                if (vs_fall) begin
                    v_total  <= lcnt;
                    lcnt     <= hs_fall ? 12'd1 : 12'd0;
                    vsw      <= hs_fall ? 12'd1 : 12'd0;
                    line_bad <= 1'b0;
                end else begin
                    if (hs_fall)
                        lcnt <= sat_inc(lcnt);
                    if (hs_fall && !vsync_n)
                        vsw <= sat_inc(vsw);
                    if (line_err)
                        line_bad <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SEARCH;
            good_cnt <= '0;
            lock_err <= 1'b0;
        end else begin
            state    <= state_nx;
            good_cnt <= good_nx;
            lock_err <= lock_err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        good_nx     = good_cnt;
        lock_err_nx = 1'b0;
        if (pix_en) begin
            case (state)
                SEARCH: begin
                    if (vs_fall) begin
                        state_nx = ACQUIRE;
                        good_nx  = '0;
                    end
                end
                ACQUIRE: begin
                    if (timeout_err) begin
                        good_nx = '0;
                    end else if (vs_fall) begin
                        if (frame_ok) begin
                            good_nx = good_cnt + 8'd1;
                            if (good_cnt + 8'd1 >= 8'(LOCK_FRAMES))
                                state_nx = LOCK;
                        end else begin
                            good_nx = '0;
                        end
                    end
                end
                LOCK: begin
                    if (line_err || (vs_fall && !frame_ok)) begin
                        lock_err_nx = 1'b1;
                        state_nx    = ACQUIRE;
                        good_nx     = '0;
                    end
                end
                default: begin
                    state_nx = SEARCH;
                    good_nx  = '0;
                end
            endcase
        end
    end

    assign locked = (state == LOCK);
    assign de     = locked && (x < 10'(H_ACTIVE)) && (y < 10'(V_ACTIVE));

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled 32x20 raster; pix_en every second clk.
module tb_vga_sync_decoder;

    localparam int HA = 16, HF = 4, HSW = 6, HB = 6;
    localparam int VA = 12, VF = 2, VSW = 2, VB = 4;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int HS0 = HA + HF;
    localparam int VS0 = VA + VF;

    logic        clk = 1'b0;
    logic        rst, pix_en, hsync_n, vsync_n;
    logic [9:0]  x, y;
    logic        de, newline, newframe, locked, lock_err;
    logic [11:0] h_total, v_total;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_n(hsync_n), .vsync_n(vsync_n),
        .x(x), .y(y), .de(de), .newline(newline), .newframe(newframe),
        .h_total(h_total), .v_total(v_total), .locked(locked), .lock_err(lock_err)
    );

    typedef struct {int ex; int ey;} exp_t;
    exp_t sbq[$];

    int checks = 0, errors = 0;
    int gy = 0, gframe = 0;
    bit sb_on = 0, cnt_on = 0, probe_on = 0;
    int err_cnt = 0, err_gx = -1, err_gy = -1;
    int rise_cnt = 0, rise_gx = -1, rise_gy = -1, rise_fr = -1;
    int de_cnt = 0, nl_cnt = 0, nf_cnt = 0;
    int probe_x = -1, probe_y = -1;
    int fr0;
    logic locked_q = 1'b0;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One pixel sample: drive on a falling edge, read the result one falling edge later.
    task automatic px(input logic hs, input logic vs, input int cx, input int cy);
        exp_t e;
        @(negedge clk);
        pix_en  = 1'b1;
        hsync_n = hs;
        vsync_n = vs;
        if (sb_on) sbq.push_back('{cx, cy});
        @(negedge clk);
        pix_en = 1'b0;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_x", int'(x), e.ex);
            chk("sb_y", int'(y), e.ey);
        end
        if (cnt_on) begin
            de_cnt += int'(de);
            nl_cnt += int'(newline);
            nf_cnt += int'(newframe);
        end
        if (lock_err) begin
            err_cnt++;
            err_gx = cx;
            err_gy = cy;
        end
        if (locked && !locked_q) begin
            rise_cnt++;
            rise_gx = cx;
            rise_gy = cy;
            rise_fr = gframe;
        end
        locked_q = locked;
        if (probe_on && cx == HS0 && cy == 0) probe_x = int'(x);
        if (probe_on && cx == 0 && cy == VS0) probe_y = int'(y);
    endtask

    task automatic gen_line(input int len, input int hw, input int vw);
        for (int i = 0; i < len; i++)
            px(!(i >= HS0 && i < HS0 + hw), !(gy >= VS0 && gy < VS0 + vw), i, gy);
        gy++;
        if (gy == VT) begin
            gy = 0;
            gframe++;
        end
    endtask

    task automatic gen_lines(input int n);
        for (int i = 0; i < n; i++) gen_line(HT, HSW, VSW);
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_de", int'(de), 0);
        chk("rst_h_total", int'(h_total), 0);
        chk("rst_v_total", int'(v_total), 0);
        chk("rst_lock_err", int'(lock_err), 0);
        chk("rst_newline", int'(newline), 0);
        chk("rst_newframe", int'(newframe), 0);
        rst = 1'b0;

        // Frames 0..2: acquisition, lock at the third vs_fall
        probe_on = 1;
        gen_lines(VT);
        probe_on = 0;
        chk("first_hs_fall_x", probe_x, HS0);
        chk("first_vs_fall_y", probe_y, VS0);
        sb_on = 1;
        gen_lines(VT);
        sb_on = 0;
        gen_lines(VS0);
        chk("pre_lock_locked", int'(locked), 0);
        gen_lines(VT - VS0);
        chk("lock_rise_cnt", rise_cnt, 1);
        chk("lock_rise_frame", rise_fr, 2);
        chk("lock_rise_line", rise_gy, VS0);
        chk("lock_rise_px", rise_gx, 0);
        chk("h_total_nom", int'(h_total), HT);
        chk("v_total_nom", int'(v_total), VT);

        // Frame 3: one fully locked frame
        sb_on = 1; cnt_on = 1;
        gen_lines(VT);
        sb_on = 0; cnt_on = 0;
        chk("de_samples", de_cnt, HA * VA);
        chk("newline_cnt", nl_cnt, VT);
        chk("newframe_cnt", nf_cnt, 1);
        chk("locked_frame_errs", err_cnt, 0);

        // Frame 4: stretched line 3 -> error at line 4 hs_fall, relock in frame 6
        gen_lines(3);
        gen_line(HT + 1, HSW, VSW);
        gen_line(HT, HSW, VSW);
        chk("stretch_err_cnt", err_cnt, 1);
        chk("stretch_err_line", err_gy, 4);
        chk("stretch_err_px", err_gx, HS0);
        chk("stretch_h_total", int'(h_total), HT + 1);
        chk("stretch_locked", int'(locked), 0);
        gen_lines(VT - 5);
        gen_lines(VT);
        gen_lines(VS0);
        chk("stretch_prelock", int'(locked), 0);
        gen_lines(VT - VS0);
        chk("stretch_rise_frame", rise_fr, 6);
        chk("stretch_rise_line", rise_gy, VS0);
        chk("stretch_err_once", err_cnt, 1);

        // Frame 7: short hsync pulse
        err_cnt = 0;
        gen_lines(3);
        gen_line(HT, HSW - 1, VSW);
        chk("hsw_err_cnt", err_cnt, 1);
        chk("hsw_err_line", err_gy, 3);
        chk("hsw_err_px", err_gx, HS0 + HSW - 1);
        chk("hsw_locked", int'(locked), 0);
        gen_lines(VT - 4);
        gen_lines(2 * VT);
        chk("hsw_relock", int'(locked), 1);

        // Frame 10: three-line vsync
        err_cnt = 0;
        for (int l = 0; l < VT; l++) gen_line(HT, HSW, VSW + 1);
        chk("vsw_err_cnt", err_cnt, 1);
        chk("vsw_err_line", err_gy, VS0 + VSW + 1);
        chk("vsw_err_px", err_gx, 0);
        chk("vsw_locked", int'(locked), 0);
        gen_lines(2 * VT);
        chk("vsw_prelock", int'(locked), 0);
        gen_lines(VT);
        chk("vsw_relock", int'(locked), 1);

        // Frame 14: hsync held high -> timeout, then saturated line length
        err_cnt = 0;
        gen_lines(3);
        gen_line(4200, 0, VSW);
        chk("tmo_err_cnt", err_cnt, 1);
        chk("tmo_err_line", err_gy, 3);
        chk("tmo_err_px", err_gx, HT + HS0 - 1);
        chk("tmo_h_total_held", int'(h_total), HT);
        chk("tmo_locked", int'(locked), 0);
        gen_line(HT, HSW, VSW);
        chk("tmo_h_total_sat", int'(h_total), 4095);
        chk("tmo_err_once", err_cnt, 1);
        gen_lines(VT - 5);
        gen_lines(2 * VT);
        chk("tmo_relock", int'(locked), 1);

        // Frame 17: reset mid-frame while locked
        err_cnt = 0;
        gen_lines(5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_x", int'(x), 0);
        chk("mid_rst_y", int'(y), 0);
        chk("mid_rst_locked", int'(locked), 0);
        chk("mid_rst_de", int'(de), 0);
        chk("mid_rst_h_total", int'(h_total), 0);
        chk("mid_rst_v_total", int'(v_total), 0);
        fr0 = gframe;
        gen_lines(VT - 5);
        gen_lines(VT);
        gen_lines(VS0);
        chk("mid_rst_prelock", int'(locked), 0);
        gen_lines(VT - VS0);
        chk("mid_rst_relock", int'(locked), 1);
        chk("mid_rst_rise_frame", rise_fr, fr0 + 2);
        chk("mid_rst_rise_line", rise_gy, VS0);
        chk("mid_rst_no_lock_err", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
